// File: rtl/hazard_unit_mc_if.sv
// Pipeline-to-hazard-unit bundle: register addresses, write enables and
// instruction kind in; forwarding selects, stall/flush controls and MDU status out.
interface hazard_unit_mc_if #(
    parameter int REG_W = 5
) ();
    logic [REG_W-1:0] rs1_ex;
    logic [REG_W-1:0] rs2_ex;
    logic [REG_W-1:0] rd_ex;
    logic [REG_W-1:0] rd_mem;
    logic [REG_W-1:0] rd_wb;
    logic             rf_en_ex;
    logic             rf_en_mem;
    logic             rf_en_wb;
    logic [REG_W-1:0] rs1_id;
    logic [REG_W-1:0] rs2_id;
    logic             rs1_used_id;
    logic             rs2_used_id;
    logic             is_load_ex;
    logic             mdu_start_ex;
    logic             br_taken;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             flush_id;
    logic             flush_ex;
    logic             flush_mem;
    logic             mdu_busy;
    logic             mdu_done;

    modport master (
        output rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb,
        output rf_en_ex, rf_en_mem, rf_en_wb,
        output rs1_id, rs2_id, rs1_used_id, rs2_used_id,
        output is_load_ex, mdu_start_ex, br_taken,
        input  forward_a, forward_b,
        input  stall_if, stall_id, stall_ex,
        input  flush_id, flush_ex, flush_mem,
        input  mdu_busy, mdu_done
    );

    modport slave (
        input  rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb,
        input  rf_en_ex, rf_en_mem, rf_en_wb,
        input  rs1_id, rs2_id, rs1_used_id, rs2_used_id,
        input  is_load_ex, mdu_start_ex, br_taken,
        output forward_a, forward_b,
        output stall_if, stall_id, stall_ex,
        output flush_id, flush_ex, flush_mem,
        output mdu_busy, mdu_done
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding controller for the 5-stage pipeline: operand forwarding,
// multi-cycle load-use stall, multi-cycle MDU stall FSM, branch flush priority.
module hazard_unit_mc #(
    parameter int REG_W    = 5,
    parameter int MDU_LAT  = 4,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 4
) (
    input logic       clk,
    input logic       rst,
    hazard_unit_mc_if.slave hz
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    localparam logic [REG_W-1:0] X0 = '0;

    mdu_state_e state_q, state_d;
    logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic mdu_stall;
    logic mdu_done;
    logic lu_hit;
    logic lu_stall;

    // MEM result is newer than WB, so it wins; x0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rd_mem,
        input logic             en_mem,
        input logic [REG_W-1:0] rd_wb,
        input logic             en_wb
    );
        if (rs != X0 && en_mem && rs == rd_mem) return 2'b10;
        if (rs != X0 && en_wb && rs == rd_wb)   return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        hz.forward_a = fwd_sel(hz.rs1_ex, hz.rd_mem, hz.rf_en_mem, hz.rd_wb, hz.rf_en_wb);
        hz.forward_b = fwd_sel(hz.rs2_ex, hz.rd_mem, hz.rf_en_mem, hz.rd_wb, hz.rf_en_wb);
    end

    always_comb begin
        lu_hit = hz.is_load_ex && hz.rf_en_ex && (hz.rd_ex != X0) &&
                 ((hz.rs1_used_id && hz.rs1_id == hz.rd_ex) ||
                  (hz.rs2_used_id && hz.rs2_id == hz.rd_ex));
        lu_stall = (lu_hit && !hz.br_taken) || (lu_cnt_q != '0);
        lu_cnt_d = lu_cnt_q;
        if (lu_cnt_q != '0) begin
            lu_cnt_d = lu_cnt_q - CNT_W'(1);
        end else if (lu_hit && !hz.br_taken) begin
            // The hit cycle itself is the first stall cycle; the counter covers the rest.
            lu_cnt_d = CNT_W'(LOAD_LAT - 1);
        end
    end

    always_comb begin
        state_d   = state_q;
        mdu_cnt_d = mdu_cnt_q;
        mdu_stall = 1'b0;
        mdu_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (hz.mdu_start_ex) begin
                    if (MDU_LAT > 1) begin
                        state_d   = BUSY;
                        mdu_cnt_d = CNT_W'(MDU_LAT - 2);
                        mdu_stall = 1'b1;
                    end else begin
                        mdu_done = 1'b1;
                    end
                end
            end
            BUSY: begin
                // Final cycle releases the pipeline without looking at mdu_start_ex.
                if (mdu_cnt_q != '0) begin
                    mdu_stall = 1'b1;
                    mdu_cnt_d = mdu_cnt_q - CNT_W'(1);
                end else begin
                    mdu_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mdu_cnt_q <= '0;
            lu_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
            lu_cnt_q  <= lu_cnt_d;
        end
    end

    always_comb begin
        hz.stall_if  = 1'b0;
        hz.stall_id  = 1'b0;
        hz.stall_ex  = 1'b0;
        hz.flush_id  = 1'b0;
        hz.flush_ex  = 1'b0;
        hz.flush_mem = 1'b0;
        hz.mdu_busy  = (state_q == BUSY);
        hz.mdu_done  = mdu_done;
        if (mdu_stall) begin
            hz.stall_if  = 1'b1;
            hz.stall_id  = 1'b1;
            hz.stall_ex  = 1'b1;
            hz.flush_mem = 1'b1;
        end else if (hz.br_taken) begin
            hz.flush_id = 1'b1;
            hz.flush_ex = 1'b1;
        end else if (lu_stall) begin
            hz.stall_if = 1'b1;
            hz.stall_id = 1'b1;
            hz.flush_ex = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed plus random stimulus on two configurations of hazard_unit_mc,
// checked against a cycle-age reference model of the stall/forward rules.
module tb_hazard_unit_mc;

    typedef struct packed {
        logic [4:0] rs1_ex;
        logic [4:0] rs2_ex;
        logic [4:0] rd_ex;
        logic [4:0] rd_mem;
        logic [4:0] rd_wb;
        logic       rf_en_ex;
        logic       rf_en_mem;
        logic       rf_en_wb;
        logic [4:0] rs1_id;
        logic [4:0] rs2_id;
        logic       rs1_used_id;
        logic       rs2_used_id;
        logic       is_load_ex;
        logic       mdu_start_ex;
        logic       br_taken;
    } in_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  cur = '0;
    in_t  nxt = '0;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int m_age[2]    = '{0, 0};
    int lu_until[2] = '{0, 0};

    always #5 clk = ~clk;

    hazard_unit_mc_if #(.REG_W(5)) if_a ();
    hazard_unit_mc_if #(.REG_W(5)) if_b ();

    hazard_unit_mc #(.REG_W(5), .MDU_LAT(4), .LOAD_LAT(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .hz(if_a.slave)
    );
    hazard_unit_mc #(.REG_W(5), .MDU_LAT(1), .LOAD_LAT(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .hz(if_b.slave)
    );

    assign {if_a.rs1_ex, if_a.rs2_ex, if_a.rd_ex, if_a.rd_mem, if_a.rd_wb,
            if_a.rf_en_ex, if_a.rf_en_mem, if_a.rf_en_wb, if_a.rs1_id, if_a.rs2_id,
            if_a.rs1_used_id, if_a.rs2_used_id, if_a.is_load_ex, if_a.mdu_start_ex,
            if_a.br_taken} = cur;
    assign {if_b.rs1_ex, if_b.rs2_ex, if_b.rd_ex, if_b.rd_mem, if_b.rd_wb,
            if_b.rf_en_ex, if_b.rf_en_mem, if_b.rf_en_wb, if_b.rs1_id, if_b.rs2_id,
            if_b.rs1_used_id, if_b.rs2_used_id, if_b.is_load_ex, if_b.mdu_start_ex,
            if_b.br_taken} = cur;

    logic [11:0] outs_a, outs_b;
    assign outs_a = {if_a.forward_a, if_a.forward_b, if_a.stall_if, if_a.stall_id,
                     if_a.stall_ex, if_a.flush_id, if_a.flush_ex, if_a.flush_mem,
                     if_a.mdu_busy, if_a.mdu_done};
    assign outs_b = {if_b.forward_a, if_b.forward_b, if_b.stall_if, if_b.stall_id,
                     if_b.stall_ex, if_b.flush_id, if_b.flush_ex, if_b.flush_mem,
                     if_b.mdu_busy, if_b.mdu_done};

    function automatic int mlat(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int llat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rs != 0 && cur.rf_en_mem && rs == cur.rd_mem) return 2'b10;
        if (rs != 0 && cur.rf_en_wb && rs == cur.rd_wb)   return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic ref_lu_hit();
        return cur.is_load_ex && cur.rf_en_ex && cur.rd_ex != 0 &&
               ((cur.rs1_used_id && cur.rs1_id == cur.rd_ex) ||
                (cur.rs2_used_id && cur.rs2_id == cur.rd_ex));
    endfunction

    // Which cycle of an MDU op (1..MDU_LAT) EX is in right now; 0 = none.
    function automatic int op_cycle(input int d);
        if (m_age[d] != 0) return m_age[d];
        return cur.mdu_start_ex ? 1 : 0;
    endfunction

    function automatic logic [11:0] model_out(input int d);
        int   cc;
        logic ms, ls;
        logic [5:0] sf;
        cc = op_cycle(d);
        ms = (cc >= 1) && (cc <= mlat(d) - 1);
        ls = (ref_lu_hit() && !cur.br_taken) || (cyc < lu_until[d]);
        if (ms)                sf = 6'b111_001;
        else if (cur.br_taken) sf = 6'b000_110;
        else if (ls)           sf = 6'b110_010;
        else                   sf = 6'b000_000;
        return {ref_fwd(cur.rs1_ex), ref_fwd(cur.rs2_ex), sf,
                logic'(m_age[d] != 0), logic'(cc == mlat(d))};
    endfunction

    task automatic model_tick();
        for (int d = 0; d < 2; d++) begin
            int cc;
            cc = op_cycle(d);
            m_age[d] = (cc != 0 && cc < mlat(d)) ? cc + 1 : 0;
            if (!(cyc < lu_until[d]) && ref_lu_hit() && !cur.br_taken)
                lu_until[d] = cyc + llat(d);
        end
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_both(input string tag);
        chk({tag, "_A"}, outs_a, model_out(0));
        chk({tag, "_B"}, outs_b, model_out(1));
    endtask

    task automatic step(input string tag);
        logic lu_act;
        @(negedge clk);
        cur = nxt;
        #1;
        lu_act = (cyc < lu_until[0]) || (cyc < lu_until[1]);
        chk({tag, "_legal"}, {10'b0, cur.br_taken && cur.mdu_start_ex, lu_act && cur.mdu_start_ex}, 12'h000);
        chk_both(tag);
        @(posedge clk);
        if (!rst) model_tick();
        cyc++;
    endtask

    initial begin
        #1;
        chk("reset_A", outs_a, 12'h000);
        chk("reset_B", outs_b, 12'h000);
        @(negedge clk);
        rst = 1'b0;

        // Forwarding priority and x0 exclusion.
        nxt = '0;
        nxt.rs1_ex = 5; nxt.rd_mem = 5; nxt.rf_en_mem = 1; nxt.rd_wb = 5; nxt.rf_en_wb = 1;
        step("fwd_mem");
        chk("fwd_mem_const", {10'b0, if_a.forward_a}, 12'h002);
        nxt.rs1_ex = 0;
        step("fwd_x0");
        chk("fwd_x0_const", {10'b0, if_a.forward_a}, 12'h000);
        nxt.rs1_ex = 5; nxt.rf_en_mem = 0; nxt.rs2_ex = 5;
        step("fwd_wb");
        chk("fwd_wb_const", {8'b0, if_a.forward_a, if_a.forward_b}, 12'h005);

        // Load-use on rs2, then with rs2 not used.
        nxt = '0;
        nxt.is_load_ex = 1; nxt.rf_en_ex = 1; nxt.rd_ex = 3; nxt.rs2_id = 3; nxt.rs2_used_id = 1;
        step("lu_hit");
        nxt = '0;
        for (int i = 0; i < 4; i++) step("lu_tail");
        nxt.is_load_ex = 1; nxt.rf_en_ex = 1; nxt.rd_ex = 3; nxt.rs2_id = 3; nxt.rs2_used_id = 0;
        step("lu_unused");
        nxt = '0;
        step("lu_unused_tail");

        // Single MDU op, then back-to-back ops with start held.
        nxt = '0; nxt.mdu_start_ex = 1;
        step("mdu_c1");
        nxt = '0;
        for (int i = 0; i < 5; i++) step("mdu_single");
        nxt.mdu_start_ex = 1;
        for (int i = 0; i < 8; i++) step("mdu_b2b");
        nxt = '0;
        for (int i = 0; i < 2; i++) step("mdu_b2b_tail");

        // Branch wins over a simultaneous load-use hit; no counter load follows.
        nxt = '0;
        nxt.is_load_ex = 1; nxt.rf_en_ex = 1; nxt.rd_ex = 7; nxt.rs1_id = 7; nxt.rs1_used_id = 1;
        nxt.br_taken = 1;
        step("br_vs_lu");
        nxt = '0;
        for (int i = 0; i < 3; i++) step("br_vs_lu_tail");

        // Asynchronous reset during the MDU stall.
        nxt = '0; nxt.mdu_start_ex = 1;
        step("mdu_rst_c1");
        @(negedge clk);
        cur = '0;
        #1;
        chk_both("mdu_rst_c2");
        rst = 1'b1;
        #1;
        m_age = '{0, 0};
        lu_until = '{0, 0};
        chk_both("rst_mid");
        chk("rst_mid_zero_A", outs_a, 12'h000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        nxt = '0; nxt.mdu_start_ex = 1;
        step("mdu_after_rst");
        nxt = '0;
        for (int i = 0; i < 4; i++) step("mdu_after_rst_tail");

        // Random legal traffic.
        for (int i = 0; i < 400; i++) begin
            logic lu_act;
            nxt = '0;
            nxt.rs1_ex      = 5'($urandom_range(3));
            nxt.rs2_ex      = 5'($urandom_range(3));
            nxt.rd_ex       = 5'($urandom_range(3));
            nxt.rd_mem      = 5'($urandom_range(3));
            nxt.rd_wb       = 5'($urandom_range(3));
            nxt.rs1_id      = 5'($urandom_range(3));
            nxt.rs2_id      = 5'($urandom_range(3));
            nxt.rf_en_ex    = 1'($urandom);
            nxt.rf_en_mem   = 1'($urandom);
            nxt.rf_en_wb    = 1'($urandom);
            nxt.rs1_used_id = 1'($urandom);
            nxt.rs2_used_id = 1'($urandom);
            nxt.br_taken    = ($urandom_range(7) == 0);
            lu_act = (cyc < lu_until[0]) || (cyc < lu_until[1]);
            nxt.mdu_start_ex = !nxt.br_taken && !lu_act && ($urandom_range(5) == 0);
            nxt.is_load_ex   = !nxt.mdu_start_ex && (m_age[0] == 0) && ($urandom_range(2) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised hazard/forwarding controller for the 5-stage pipeline.
- Adds three things to the basic forwarding and load-use logic:
  - a multi-cycle MUL/DIV (MDU) stall FSM,
  - a multi-cycle load-use stall counter (configurable dmem latency),
  - per-source "used" qualifiers that remove spurious stalls.
- Drives the stall and flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers.

Parameters:
- REG_W, 5, register-address width.
- MDU_LAT, 4, cycles an MDU op occupies EX (>=1).
- LOAD_LAT, 1, load-use stall cycles (>=1).
- CNT_W, 4, counter width; must hold max(MDU_LAT, LOAD_LAT).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rs1_ex, rs2_ex  in  REG_W  EX source registers.
- rd_ex, rd_mem, rd_wb  in  REG_W  destination registers per stage.
- rf_en_ex, rf_en_mem, rf_en_wb  in  1  register-write enable per stage.
- rs1_id, rs2_id  in  REG_W  ID source registers.
- rs1_used_id, rs2_used_id  in  1  ID instruction actually reads that source.
- is_load_ex  in  1  EX instruction is a load.
- mdu_start_ex  in  1  EX instruction is an MDU op.
- br_taken  in  1  branch/jump redirect resolved in EX.
- forward_a, forward_b  out  2  operand mux select: 00 = RF, 10 = MEM, 01 = WB.
- stall_if, stall_id, stall_ex  out  1  hold PC / IF-ID / ID-EX.
- flush_id, flush_ex, flush_mem  out  1  bubble into IF-ID / ID-EX / EX-MEM.
- mdu_busy  out  1  FSM in BUSY.
- mdu_done  out  1  MDU result valid this cycle.

Behaviour:
- Forwarding (combinational):
  - forward_a = 10 if rs1_ex==rd_mem & rf_en_mem & rs1_ex!=0.
  - Else 01 if rs1_ex==rd_wb & rf_en_wb & rs1_ex!=0.
  - Else 00.
  - forward_b is the same using rs2_ex. MEM always beats WB; x0 is never forwarded.
- Load-use detect (combinational):
  - lu_hit = is_load_ex & rf_en_ex & rd_ex!=0 & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)).
- Load-use counter lu_cnt (CNT_W bits, reset 0):
  - On lu_hit with lu_cnt==0 and !br_taken: lu_cnt <= LOAD_LAT-1.
  - While lu_cnt!=0: lu_cnt decrements by 1.
  - lu_stall = (lu_hit & !br_taken) | (lu_cnt!=0).
  - Result: the dependent instruction is held in ID for exactly LOAD_LAT cycles, with a bubble into EX each of those cycles.
- MDU FSM, states IDLE and BUSY; mdu_cnt reset 0:
  - IDLE, mdu_start_ex=1, MDU_LAT>1: go to BUSY, mdu_cnt <= MDU_LAT-2, mdu_stall=1 this cycle.
  - IDLE, MDU_LAT==1: stay IDLE, no stall; mdu_done=1 while mdu_start_ex.
  - BUSY, mdu_cnt!=0: mdu_stall=1, mdu_cnt decrements.
  - BUSY, mdu_cnt==0: mdu_stall=0, mdu_done=1, next state IDLE. mdu_start_ex is not re-sampled in this cycle.
  - Total stall cycles per MDU op = MDU_LAT-1.
  - mdu_busy = (state==BUSY).
- Outputs, in priority order:
  1. mdu_stall: stall_if = stall_id = stall_ex = 1, flush_mem = 1; flush_id = flush_ex = 0; br_taken and lu_stall are ignored.
  2. br_taken: flush_id = flush_ex = 1; all stalls 0; load-use is suppressed and lu_cnt is not loaded.
  3. lu_stall: stall_if = stall_id = 1, flush_ex = 1.
  4. Otherwise all stall/flush outputs are 0.
- Impossible combinations (bench flags with assertions):
  - br_taken together with mdu_start_ex.
  - lu_cnt!=0 while mdu_start_ex=1; EX holds a bubble during a load-use stall.
- Reset:
  - State, mdu_cnt and lu_cnt clear asynchronously.
  - A reset in the middle of an MDU op or load-use stall drops all stalls immediately.
  - With inputs at 0, every output is 0 (forward_* = 00, mdu_busy = mdu_done = 0).

Test Plan:
1. Forwarding: rs1_ex=5, rd_mem=5, rf_en_mem=1, rd_wb=5, rf_en_wb=1 -> forward_a=10. Repeat with rs1_ex=0 -> forward_a=00. With rf_en_mem=0 -> forward_a=01.
2. Load-use, LOAD_LAT=1: load with rd_ex=3 in EX, rs2_id=3 and rs2_used_id=1 -> one cycle of stall_if=stall_id=flush_ex=1. With rs2_used_id=0 -> no stall.
3. Load-use, LOAD_LAT=3: same stimulus -> stall_if/stall_id/flush_ex high for exactly 3 consecutive cycles, then 0.
4. MDU, MDU_LAT=4: mdu_start_ex held for one op -> stall_ex=flush_mem=1 for 3 cycles, mdu_busy=1 for cycles 2-4, mdu_done=1 on cycle 4, IDLE on cycle 5. Back-to-back MDU ops -> two separate 3-cycle stalls.
5. Branch vs load-use: lu_hit and br_taken in the same cycle -> flush_id=flush_ex=1, stall_if=0, lu_cnt stays 0.
6. Reset mid-MDU: assert rst in cycle 2 of the MDU stall -> stalls and mdu_busy go to 0 without waiting for clk. After release, a new mdu_start_ex stalls the full MDU_LAT-1 cycles.
